// File: rtl/control_seq_if.sv
// Fetch/datapath-facing bundle for the control sequencer: instruction handshake,
// memory ready, flags, interrupt request and all decode outputs.
interface control_seq_if #(parameter int NSIG = 8);
  logic [7:0]      inst;
  logic            inst_valid;
  logic            inst_ack;
  logic            mem_rdy;
  logic            carry;
  logic            irq;
  logic            int_take;
  logic            cycle;
  logic            M, MW, MC, J, LJ, CLI, LJR, RD, WR, WA, WC, ISP;
  logic            S, Y;
  logic [1:0]      RS;
  logic [3:0]      ALU;
  logic [NSIG-1:0] SIG;
  logic            busy;

  modport master (
    output inst, inst_valid, mem_rdy, carry, irq,
    input  inst_ack, int_take, cycle, M, MW, MC, J, LJ, CLI, LJR, RD, WR, WA, WC, ISP,
           S, Y, RS, ALU, SIG, busy
  );

  modport slave (
    input  inst, inst_valid, mem_rdy, carry, irq,
    output inst_ack, int_take, cycle, M, MW, MC, J, LJ, CLI, LJR, RD, WR, WA, WC, ISP,
           S, Y, RS, ALU, SIG, busy
  );
endinterface

// File: rtl/control_seq.sv
// Multi-cycle Nandy control sequencer: owns IR, phase bit, memory wait states and
// a single-level interrupt enable; decode strobes are qualified by sequencer state.
module control_seq #(
  parameter int WAIT_STATES = 0,
  parameter int NSIG        = 8
) (
  input logic        clk,
  input logic        rst_n,
  control_seq_if.slave bus
);
  typedef enum logic [2:0] {FETCH, EXEC, ADDR, MEM, INT} state_t;

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  state_t     state;
  logic [7:0] ir;
  logic       ie;
  logic [2:0] waitCnt;

  logic inFetch, inExec, inAddr, inMem, inInt;
  logic intReq, memDone, cliDec;
  logic lj, isp, memOp, lowGrp, waKeep, sigOp;

  assign inFetch = (state == FETCH);
  assign inExec  = (state == EXEC);
  assign inAddr  = (state == ADDR);
  assign inMem   = (state == MEM);
  assign inInt   = (state == INT);

  assign intReq  = bus.irq & ie;
  // Early mem_rdy is ignored; it only counts once the wait budget is spent.
  assign memDone = (waitCnt >= WS) & bus.mem_rdy;

  assign lj     = (ir[7:3] == 5'b00010);
  assign cliDec = lj & ir[1];
  assign isp    = (ir[7:5] == 3'b001);
  assign memOp  = ir[7] & ~ir[6];
  assign lowGrp = (ir[7:4] == 4'b0000);
  assign waKeep = ~(ir[4] & ~ir[3]);
  assign sigOp  = (ir[7:3] == 5'b00011);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      ir      <= 8'h00;
      ie      <= 1'b0;
      waitCnt <= 3'd0;
    end else begin
      case (state)
        FETCH: begin
          // Interrupt has priority over a pending instruction.
          if (intReq) begin
            state <= INT;
          end else if (bus.inst_valid) begin
            ir    <= bus.inst;
            state <= bus.inst[7] ? ADDR : EXEC;
          end
        end
        EXEC: begin
          if (cliDec) ie <= 1'b1;
          state <= FETCH;
        end
        ADDR: begin
          waitCnt <= 3'd0;
          state   <= MEM;
        end
        MEM: begin
          if (waitCnt != 3'd7) waitCnt <= waitCnt + 3'd1;
          if (memDone) state <= FETCH;
        end
        INT: begin
          ie    <= 1'b0;
          state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign bus.inst_ack = inFetch & bus.inst_valid & ~intReq;
  assign bus.int_take = inInt;
  assign bus.cycle    = inMem;
  assign bus.busy     = ~inFetch;

  assign bus.M   = inMem & memOp;
  assign bus.MW  = inMem & memOp & ir[5];
  assign bus.J   = inMem & (ir[7:5] == 3'b111) & ~(bus.carry & ir[4]);
  assign bus.MC  = inAddr;
  assign bus.LJ  = inExec & lj;
  assign bus.CLI = inExec & cliDec;
  assign bus.LJR = inExec & lj & ir[2];
  assign bus.RD  = inExec & lowGrp & ir[2];
  assign bus.WR  = inExec & lowGrp & ir[3];
  assign bus.ISP = inExec & isp;

  assign bus.WA = (inMem  & ((memOp & ~ir[5]) | (ir[6] & ~ir[5] & waKeep)))
                | (inExec & ir[6] & ~ir[7] & waKeep);
  assign bus.WC = ir[4] & ((inExec & ((ir[6] & ~ir[7]) | isp)) | (inMem & ir[6] & ir[5]));

  assign bus.S   = ir[4];
  assign bus.Y   = ir[5];
  assign bus.RS  = ir[1:0];
  assign bus.ALU = ir[3:0];

  // One strobe per implemented signal line; indices >= NSIG have no line.
  for (genvar i = 0; i < NSIG; i++) begin : gSig
    assign bus.SIG[i] = inExec & sigOp & (ir[2:0] == 3'(i));
  end
endmodule

// File: tb/tb_control_seq.sv
// Bench for control_seq: two parameterisations driven in lockstep, a phase-level
// model compared every cycle, plus directed literal expectations.
module tb_control_seq;
  localparam int PF = 0, PE = 1, PA = 2, PM = 3, PI = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] inst;
  logic       instValid, memRdy, carry, irq;

  int nChecks = 0;
  int nFail   = 0;

  control_seq_if #(.NSIG(8)) if0 ();
  control_seq_if #(.NSIG(4)) if1 ();

  assign if0.inst = inst; assign if0.inst_valid = instValid; assign if0.mem_rdy = memRdy;
  assign if0.carry = carry; assign if0.irq = irq;
  assign if1.inst = inst; assign if1.inst_valid = instValid; assign if1.mem_rdy = memRdy;
  assign if1.carry = carry; assign if1.irq = irq;

  control_seq #(.WAIT_STATES(0), .NSIG(8)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  control_seq #(.WAIT_STATES(2), .NSIG(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] obs [2];
  assign obs[0] = {if0.inst_ack, if0.int_take, if0.cycle, if0.M, if0.MW, if0.MC, if0.J,
                   if0.LJ, if0.CLI, if0.LJR, if0.RD, if0.WR, if0.WA, if0.WC, if0.ISP,
                   if0.S, if0.Y, if0.RS, if0.ALU, if0.SIG, if0.busy};
  assign obs[1] = {if1.inst_ack, if1.int_take, if1.cycle, if1.M, if1.MW, if1.MC, if1.J,
                   if1.LJ, if1.CLI, if1.LJR, if1.RD, if1.WR, if1.WA, if1.WC, if1.ISP,
                   if1.S, if1.Y, if1.RS, if1.ALU, 4'b0, if1.SIG, if1.busy};

  // Model: phase per instance, IR, ie, and number of MEM cycles already spent.
  int         mPh  [2];
  logic [7:0] mIr  [2];
  logic       mIe  [2];
  int         mCyc [2];
  int         wsOf [2] = '{0, 2};
  int         nsOf [2] = '{8, 4};

  function automatic logic [31:0] expOut(int ph, logic [7:0] ir, logic ie, int nsig,
                                         logic valid, logic irqIn, logic cy);
    int   hi3 = int'(ir) >> 5;
    int   hi4 = int'(ir) >> 4;
    int   hi5 = int'(ir) >> 3;
    int   idx = int'(ir) % 8;
    logic m = (ph == PM);
    logic e = (ph == PE);
    logic memOp = ((int'(ir) >> 6) == 2);
    logic lj = (hi5 == 2);
    logic isp = (hi3 == 1);
    logic noA = ir[4] && !ir[3];
    logic ack = (ph == PF) && valid && !(irqIn && ie);
    logic oM = m && memOp;
    logic oJ = m && (hi3 == 7) && !(cy && ir[4]);
    logic oWA = (m && ((memOp && !ir[5]) || (ir[6] && !ir[5] && !noA)))
             || (e && ir[6] && !ir[7] && !noA);
    logic oWC = ir[4] && ((e && ((ir[6] && !ir[7]) || isp)) || (m && ir[6] && ir[5]));
    logic [7:0] sig = 8'h00;
    if (e && hi5 == 3 && idx < nsig) sig = 8'(1 << idx);
    return {ack, ph == PI, m, oM, oM && ir[5], ph == PA, oJ,
            e && lj, e && lj && ir[1], e && lj && ir[2],
            e && hi4 == 0 && ir[2], e && hi4 == 0 && ir[3], oWA, oWC, e && isp,
            ir[4], ir[5], ir[1:0], ir[3:0], sig, ph != PF};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        mPh[i] <= PF; mIr[i] <= 8'h00; mIe[i] <= 1'b0; mCyc[i] <= 0;
      end else begin
        case (mPh[i])
          PF: if (irq && mIe[i]) mPh[i] <= PI;
              else if (instValid) begin mIr[i] <= inst; mPh[i] <= inst[7] ? PA : PE; end
          PE: begin
            if ((mIr[i] >> 3) == 8'd2 && mIr[i][1]) mIe[i] <= 1'b1;
            mPh[i] <= PF;
          end
          PA: begin mCyc[i] <= 0; mPh[i] <= PM; end
          PM: begin
            if (mCyc[i] >= wsOf[i] && memRdy) mPh[i] <= PF;
            mCyc[i] <= (mCyc[i] < 7) ? mCyc[i] + 1 : 7;
          end
          default: begin mIe[i] <= 1'b0; mPh[i] <= PF; end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [31:0] e;
      e = expOut(mPh[i], mIr[i], mIe[i], nsOf[i], instValid, irq, carry);
      nChecks++;
      if (obs[i] !== e) begin
        nFail++;
        $display("FAIL outputs_dut%0d t=%0t actual=%h required=%h", i, $time, obs[i], e);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    nChecks++;
    if (act !== req) begin
      nFail++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  int c0, c1, c1m, cy0, cy1;
  logic b5, b6;
  logic [7:0] extra [7] = '{8'h0C, 8'h3F, 8'h50, 8'h48, 8'hC0, 8'h90, 8'h16};

  initial begin
    rst_n = 1'b0; inst = 8'h00; instValid = 1'b0; memRdy = 1'b0; carry = 1'b0; irq = 1'b0;
    step(); step(); rst_n = 1'b1;
    neg();
    chk("rst_busy", 32'(if0.busy), 0);
    chk("rst_fields", 32'({if0.S, if0.Y, if0.RS, if0.ALU}), 0);
    chk("rst_ack_idle", 32'(if0.inst_ack), 0);

    // Store, then reset in the middle of MEM.
    step(); inst = 8'hA0; instValid = 1'b1;
    neg(); chk("store_ack", 32'(if0.inst_ack), 1);
    step(); instValid = 1'b0;
    neg(); chk("addr_mc", 32'({if0.MC, if1.MC, if0.cycle}), 32'b110);
    step();
    neg(); chk("mem_m_mw", 32'({if0.cycle, if0.M, if0.MW}), 32'b111);
    step(); rst_n = 1'b0;
    neg();
    chk("rstmem_busy", 32'({if0.busy, if1.busy, if0.cycle, if0.M, if0.MW}), 0);
    chk("rstmem_ir", 32'({if0.S, if0.Y, if0.RS, if0.ALU}), 0);
    step(); rst_n = 1'b1;
    neg(); chk("post_rst_busy", 32'({if0.busy, if1.busy}), 0);

    // SIG strobe, index 5.
    step(); inst = 8'h1D; instValid = 1'b1;
    neg(); chk("sig_ack", 32'(if0.inst_ack), 1);
    step(); instValid = 1'b0;
    neg();
    chk("sig_nsig8", 32'(if0.SIG), 32'h20);
    chk("sig_nsig4", 32'(if1.SIG), 0);
    step();
    neg(); chk("sig_after", 32'(if0.SIG), 0);

    // Store with mem_rdy held high: dut0 WS=0, dut1 WS=2.
    step(); inst = 8'hA0; instValid = 1'b1; memRdy = 1'b1;
    step(); instValid = 1'b0;
    c0 = 0; c1 = 0; c1m = 0;
    for (int k = 0; k < 8; k++) begin
      neg();
      c0 += int'(if0.busy); c1 += int'(if1.busy);
      c1m += int'(if1.cycle && if1.M && if1.MW);
      step();
    end
    chk("ws0_busy_cycles", 32'(c0), 2);
    chk("ws2_busy_cycles", 32'(c1), 4);
    chk("ws2_mem_cycles", 32'(c1m), 3);

    // Conditional jump following live carry.
    memRdy = 1'b0; inst = 8'hF0; instValid = 1'b1; carry = 1'b0;
    step(); instValid = 1'b0;
    step();
    neg(); chk("jc_carry0", 32'(if0.J), 1);
    step(); carry = 1'b1;
    neg(); chk("jc_carry1", 32'(if0.J), 0);
    step(); carry = 1'b0;
    neg(); chk("jc_carry0b", 32'(if0.J), 1);
    step(); memRdy = 1'b1;
    step(); inst = 8'hE0; instValid = 1'b1; carry = 1'b1;
    step(); instValid = 1'b0;
    step();
    neg(); chk("j_uncond", 32'({if0.J, if1.J}), 32'b11);
    repeat (4) step();
    carry = 1'b0;

    // irq with ie=0, then CLI.
    irq = 1'b1; inst = 8'h00; instValid = 1'b1;
    neg(); chk("irq_masked_ack", 32'({if0.inst_ack, if0.int_take}), 32'b10);
    step(); instValid = 1'b0;
    step(); inst = 8'h12; instValid = 1'b1;
    neg(); chk("cli_ack", 32'(if0.inst_ack), 1);
    step(); inst = 8'h00;
    neg(); chk("cli_strobe", 32'({if0.CLI, if0.LJ}), 32'b11);
    step();
    neg(); chk("irq_wins_ack", 32'({if0.inst_ack, if1.inst_ack}), 0);
    step();
    neg(); chk("int_take", 32'({if0.int_take, if1.int_take, if0.inst_ack}), 32'b110);
    step();
    neg(); chk("ie_cleared", 32'({if0.inst_ack, if0.int_take}), 32'b10);
    step(); irq = 1'b0; instValid = 1'b0;
    step();

    // mem_rdy low for 4 MEM cycles with WS=0.
    inst = 8'h80; instValid = 1'b1; memRdy = 1'b0;
    step(); instValid = 1'b0;
    cy0 = 0; cy1 = 0; b5 = 1'b0; b6 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      neg();
      cy0 += int'(if0.cycle); cy1 += int'(if1.cycle);
      if (k == 5) b5 = if0.busy;
      if (k == 6) b6 = if0.busy;
      step();
      if (k == 4) memRdy = 1'b1;
    end
    chk("memwait_cycle0", 32'(cy0), 5);
    chk("memwait_cycle1", 32'(cy1), 5);
    chk("memwait_busy", 32'({b5, b6}), 32'b10);

    // Remaining decode patterns, covered by the per-cycle model.
    foreach (extra[j]) begin
      inst = extra[j]; instValid = 1'b1;
      step(); instValid = 1'b0;
      repeat (4) step();
    end

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
